// File: rtl/decouple_arb_pkg.sv
// Shared types and helpers for the round-robin decouple arbiter.
package decouple_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  // Increment with wrap at num, so the requester after NUM-1 is 0.
  function automatic int rr_next(input int idx, input int num);
    return (idx + 1 >= num) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/decouple_rr_arbiter_if.sv
// dti valid/ready channel carrying a W-bit data beat.
interface decouple_rr_arbiter_if #(
  parameter int W = 16
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input  ready);
  modport consumer (input  valid, input  data, output ready);
endinterface

// File: rtl/rr_priority_pick.sv
// Round-robin priority pick: first valid index at or after ptr, wrapping mod NUM.
module rr_priority_pick #(
  parameter int NUM   = 2,
  parameter int W_SEL = $clog2(NUM)
) (
  input  logic [NUM-1:0]   valid,
  input  logic [W_SEL-1:0] ptr,
  output logic             any_valid,
  output logic [W_SEL-1:0] pick
);
  logic [2*NUM-1:0] dbl;

  // Scanning the doubled vector downward and overwriting leaves the lowest
  // position >= ptr, i.e. the first requester in ptr..ptr+NUM-1 order.
  always_comb begin
    dbl       = {valid, valid};
    any_valid = |valid;
    pick      = '0;
    for (int k = 2*NUM-1; k >= 0; k--) begin
      if (dbl[k] && k >= int'(ptr)) pick = W_SEL'(k % NUM);
    end
  end
endmodule

// File: rtl/decouple_rr_arbiter.sv
// Round-robin arbiter sharing one dti channel between NUM requesters, tagging
// each beat with its source index and optionally locking until an eot beat.
module decouple_rr_arbiter
  import decouple_arb_pkg::*;
#(
  parameter int NUM      = 2,
  parameter int DIN      = 16,
  parameter int LOCK_EOT = 0,
  parameter int W_SEL    = $clog2(NUM)
) (
  input  logic clk,
  input  logic rst,
  decouple_rr_arbiter_if.consumer din [NUM],
  decouple_rr_arbiter_if.producer dout,
  output logic locked
);
  arb_state_t             state, state_n;
  logic [W_SEL-1:0]       ptr, ptr_n, gidx, gidx_n, pick, sel;
  logic                   any_valid, hs, eot;
  logic [NUM-1:0]         vld, rdy;
  logic [NUM-1:0][DIN-1:0] dat;

  for (genvar g = 0; g < NUM; g++) begin : g_ch
    assign vld[g]       = din[g].valid;
    assign dat[g]       = din[g].data;
    assign din[g].ready = rdy[g];
  end

  rr_priority_pick #(.NUM(NUM), .W_SEL(W_SEL)) u_pick (
    .valid     (vld),
    .ptr       (ptr),
    .any_valid (any_valid),
    .pick      (pick)
  );

  // Forward path: once a grant is held the presented beat cannot move to
  // another requester, even one with higher round-robin priority.
  always_comb begin
    sel        = (state == IDLE) ? pick : gidx;
    dout.valid = (state == IDLE) ? any_valid : vld[gidx];
    dout.data  = {sel, dat[sel]};
    hs         = dout.valid & dout.ready;
    eot        = dat[sel][DIN-1];
    rdy        = '0;
    if (!rst && (state != IDLE || any_valid)) rdy[sel] = dout.ready;
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gidx_n  = gidx;
    unique case (state)
      IDLE: begin
        if (dout.valid && !dout.ready) begin
          state_n = HOLD;
          gidx_n  = pick;
        end else if (hs) begin
          if (LOCK_EOT != 0 && !eot) begin
            state_n = LOCKED;
            gidx_n  = pick;
          end else begin
            ptr_n = W_SEL'(rr_next(int'(pick), NUM));
          end
        end
      end
      HOLD: begin
        if (hs) begin
          if (LOCK_EOT != 0 && !eot) begin
            state_n = LOCKED;
          end else begin
            state_n = IDLE;
            ptr_n   = W_SEL'(rr_next(int'(gidx), NUM));
          end
        end
      end
      LOCKED: begin
        if (hs && eot) begin
          state_n = IDLE;
          ptr_n   = W_SEL'(rr_next(int'(gidx), NUM));
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      gidx   <= '0;
      locked <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      gidx   <= gidx_n;
      locked <= (state_n == LOCKED);
    end
  end
endmodule

// File: tb/tb_decouple_rr_arbiter.sv
// Self-checking bench: three arbiter configurations against a queue-free
// owner/pointer reference model, plus table vectors and hand sequences.
module tb_decouple_rr_arbiter;
  localparam int NI = 3;
  localparam int NUMS  [NI] = '{4, 2, 3};
  localparam int LOCKS [NI] = '{0, 1, 0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]       in_v  [NI];
  logic [3:0][15:0] in_d  [NI];
  logic             in_dr [NI];
  logic             act_v [NI];
  logic [31:0]      act_d [NI];
  logic [3:0]       act_r [NI];
  logic             act_lk[NI];

  logic [3:0] a_r; logic [1:0] b_r; logic [2:0] c_r;
  logic a_lk, b_lk, c_lk;

  decouple_rr_arbiter_if #(.W(16)) a_din [4] ();
  decouple_rr_arbiter_if #(.W(18)) a_dout ();
  decouple_rr_arbiter_if #(.W(16)) b_din [2] ();
  decouple_rr_arbiter_if #(.W(17)) b_dout ();
  decouple_rr_arbiter_if #(.W(16)) c_din [3] ();
  decouple_rr_arbiter_if #(.W(18)) c_dout ();

  for (genvar g = 0; g < 4; g++) begin : g_a
    assign a_din[g].valid = in_v[0][g];
    assign a_din[g].data  = in_d[0][g];
    assign a_r[g]         = a_din[g].ready;
  end
  for (genvar g = 0; g < 2; g++) begin : g_b
    assign b_din[g].valid = in_v[1][g];
    assign b_din[g].data  = in_d[1][g];
    assign b_r[g]         = b_din[g].ready;
  end
  for (genvar g = 0; g < 3; g++) begin : g_c
    assign c_din[g].valid = in_v[2][g];
    assign c_din[g].data  = in_d[2][g];
    assign c_r[g]         = c_din[g].ready;
  end

  assign a_dout.ready = in_dr[0];
  assign b_dout.ready = in_dr[1];
  assign c_dout.ready = in_dr[2];
  assign act_v[0] = a_dout.valid;  assign act_d[0] = 32'(a_dout.data);
  assign act_v[1] = b_dout.valid;  assign act_d[1] = 32'(b_dout.data);
  assign act_v[2] = c_dout.valid;  assign act_d[2] = 32'(c_dout.data);
  assign act_r[0] = a_r;  assign act_r[1] = {2'b00, b_r};  assign act_r[2] = {1'b0, c_r};
  assign act_lk[0] = a_lk; assign act_lk[1] = b_lk; assign act_lk[2] = c_lk;

  decouple_rr_arbiter #(.NUM(4), .DIN(16), .LOCK_EOT(0)) u_a (
    .clk(clk), .rst(rst), .din(a_din), .dout(a_dout), .locked(a_lk));
  decouple_rr_arbiter #(.NUM(2), .DIN(16), .LOCK_EOT(1)) u_b (
    .clk(clk), .rst(rst), .din(b_din), .dout(b_dout), .locked(b_lk));
  decouple_rr_arbiter #(.NUM(3), .DIN(16), .LOCK_EOT(0)) u_c (
    .clk(clk), .rst(rst), .din(c_din), .dout(c_dout), .locked(c_lk));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: own < 0 means no requester currently owns the channel.
  typedef struct { int ptr; int own; bit lck; } mdl_t;
  mdl_t m [NI];

  function automatic int mpick(input mdl_t s, input int num, input logic [3:0] v);
    for (int k = 0; k < num; k++) if (v[(s.ptr + k) % num]) return (s.ptr + k) % num;
    return -1;
  endfunction

  task automatic mcheck(input int i);
    int p, s; logic ev; logic [3:0] er;
    p  = mpick(m[i], NUMS[i], in_v[i]);
    s  = (m[i].own >= 0) ? m[i].own : p;
    ev = (m[i].own >= 0) ? in_v[i][m[i].own] : (p >= 0);
    er = '0;
    if (!rst && s >= 0) er[s] = in_dr[i];
    chk($sformatf("i%0d valid", i),  32'(act_v[i]),  32'(ev));
    chk($sformatf("i%0d ready", i),  32'(act_r[i]),  32'(er));
    chk($sformatf("i%0d locked", i), 32'(act_lk[i]), 32'(m[i].lck));
    if (ev) chk($sformatf("i%0d data", i), act_d[i], (32'(s) << 16) | 32'(in_d[i][s]));
  endtask

  task automatic mstep(input int i);
    int p, s; bit ov, hs, eot;
    if (rst) begin m[i] = '{0, -1, 1'b0}; return; end
    p   = mpick(m[i], NUMS[i], in_v[i]);
    s   = (m[i].own >= 0) ? m[i].own : p;
    ov  = (m[i].own >= 0) ? in_v[i][m[i].own] : (p >= 0);
    hs  = ov && in_dr[i];
    eot = (s >= 0) && in_d[i][s][15];
    if (m[i].own < 0) begin
      if (ov && !in_dr[i]) m[i].own = s;
      else if (hs) begin
        if (LOCKS[i] != 0 && !eot) begin m[i].own = s; m[i].lck = 1'b1; end
        else m[i].ptr = (s + 1) % NUMS[i];
      end
    end else if (hs) begin
      if (LOCKS[i] != 0 && !eot) m[i].lck = 1'b1;
      else begin
        m[i].ptr = (m[i].own + 1) % NUMS[i];
        m[i].own = -1;
        m[i].lck = 1'b0;
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    for (int i = 0; i < NI; i++) mcheck(i);
  endtask

  task automatic at_pos();
    @(posedge clk);
    for (int i = 0; i < NI; i++) mstep(i);
    #1;
  endtask

  typedef struct { logic [3:0] v; logic dr; logic ev; int sel; logic [3:0] er; } vec_t;
  vec_t tbl [$];

  initial begin
    // Fairness, idle, ptr retention, hold against a higher-priority newcomer.
    for (int k = 0; k < 6; k++) tbl.push_back('{4'hF, 1'b1, 1'b1, k % 4, 4'(1 << (k % 4))});
    for (int k = 0; k < 5; k++) tbl.push_back('{4'h0, 1'b1, 1'b0, 0, 4'h0});
    tbl.push_back('{4'hF, 1'b1, 1'b1, 2, 4'h4});
    for (int k = 0; k < 3; k++) tbl.push_back('{4'h4, 1'b0, 1'b1, 2, 4'h0});
    tbl.push_back('{4'h5, 1'b0, 1'b1, 2, 4'h0});
    tbl.push_back('{4'h5, 1'b1, 1'b1, 2, 4'h4});
    tbl.push_back('{4'h5, 1'b1, 1'b1, 0, 4'h1});

    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      in_v[i] = '0; in_dr[i] = 1'b0; in_d[i] = '0; m[i] = '{0, -1, 1'b0};
    end
    for (int g = 0; g < 4; g++) in_d[0][g] = (g == 2) ? 16'h1234 : 16'h0A00 + 16'(g);
    @(posedge clk); #1;
    at_neg(); at_pos();
    rst = 1'b0;

    foreach (tbl[r]) begin
      in_v[0] = tbl[r].v; in_dr[0] = tbl[r].dr;
      at_neg();
      chk($sformatf("tbl%0d valid", r), 32'(act_v[0]), 32'(tbl[r].ev));
      chk($sformatf("tbl%0d ready", r), 32'(act_r[0]), 32'(tbl[r].er));
      chk($sformatf("tbl%0d locked", r), 32'(act_lk[0]), 32'd0);
      if (tbl[r].ev)
        chk($sformatf("tbl%0d data", r), act_d[0],
            (32'(tbl[r].sel) << 16) | ((tbl[r].sel == 2) ? 32'h1234 : 32'h0A00 + 32'(tbl[r].sel)));
      at_pos();
    end
    in_v[0] = '0;

    // Locked packet on requester 1 with a mid-packet valid gap.
    rst = 1'b1; at_neg(); at_pos(); rst = 1'b0;
    in_dr[1] = 1'b1; in_v[1] = 4'b0011; in_d[1][0] = 16'h8001; in_d[1][1] = 16'h0011;
    at_neg(); chk("lk pre sel", 32'(act_d[1][16]), 32'd0); at_pos();
    at_neg(); chk("lk b1 sel", 32'(act_d[1][16]), 32'd1); chk("lk b1 lk", 32'(act_lk[1]), 32'd0); at_pos();
    in_v[1] = 4'b0001;
    at_neg(); chk("lk gap valid", 32'(act_v[1]), 32'd0); chk("lk gap lk", 32'(act_lk[1]), 32'd1); at_pos();
    in_v[1] = 4'b0011; in_d[1][1] = 16'h0022;
    at_neg(); chk("lk b2 sel", 32'(act_d[1][16]), 32'd1); at_pos();
    in_d[1][1] = 16'h8033;
    at_neg(); chk("lk b3 sel", 32'(act_d[1][16]), 32'd1); chk("lk b3 lk", 32'(act_lk[1]), 32'd1); at_pos();
    in_d[1][1] = 16'h0055;
    at_neg(); chk("lk post lk", 32'(act_lk[1]), 32'd0); chk("lk post sel", 32'(act_d[1][16]), 32'd0); at_pos();
    at_neg(); chk("rs lock sel", 32'(act_d[1][16]), 32'd1); at_pos();
    rst = 1'b1;
    at_neg(); chk("rs ready", 32'(act_r[1]), 32'd0); chk("rs lk held", 32'(act_lk[1]), 32'd1); at_pos();
    rst = 1'b0;
    at_neg(); chk("rs after lk", 32'(act_lk[1]), 32'd0); chk("rs after sel", 32'(act_d[1][16]), 32'd0); at_pos();
    in_v[1] = '0;

    // NUM=3 wrap from index 2 back to 0.
    in_dr[2] = 1'b1; in_v[2] = 4'b0010;
    at_neg(); chk("wr sel1", 32'(act_d[2][17:16]), 32'd1); at_pos();
    in_v[2] = 4'b0101;
    at_neg(); chk("wr sel2", 32'(act_d[2][17:16]), 32'd2); at_pos();
    at_neg(); chk("wr sel0", 32'(act_d[2][17:16]), 32'd0); at_pos();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 60) == 0);
      for (int i = 0; i < NI; i++) begin
        in_v[i]  = 4'($urandom) & 4'((1 << NUMS[i]) - 1);
        in_dr[i] = ($urandom_range(0, 3) != 0);
        for (int g = 0; g < 4; g++) begin
          in_d[i][g] = 16'($urandom);
          in_d[i][g][15] = ($urandom_range(0, 2) == 0);
        end
      end
      at_neg(); at_pos();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/decouple_rr_arbiter.md
Name: decouple_rr_arbiter

Overview:
- Round-robin arbiter sharing one downstream dti channel (typically a decouple buffer input) between NUM requesters.
- Tags each forwarded beat with its source index.
- Optionally locks the grant for a whole multi-beat transaction, terminated by an eot bit.
- Zero-latency combinational forward path; grant, hold and lock state are registered.

Parameters:
- NUM, 2, number of requesting channels (NUM >= 2).
- DIN, 16, data width of each requester channel.
- LOCK_EOT, 0, 1 = keep grant until a beat with din.data[DIN-1] == 1 (eot) is transferred; 0 = re-arbitrate after every beat.
- W_SEL, $clog2(NUM), width of the source index field (derived; not overridden).

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; synchronous, active-high.
- din[NUM], dti.consumer, DIN, requester channels.
- dout, dti.producer, W_SEL+DIN, output beat: data = {sel, din[sel].data}, sel in the MSBs.
- locked, output, 1, registered; high while in LOCKED state.

Behaviour:
- State register values: IDLE, HOLD, LOCKED. Reset: state=IDLE, ptr=0, gidx=0, locked=0.
- ptr is the round-robin start index.
- pick = first i with din[i].valid, scanning ptr, ptr+1, ..., NUM-1, 0, ..., ptr-1 (wraps mod NUM).
- IDLE:
  - dout.valid = |din[*].valid; sel = pick.
  - If no input is valid: dout.valid=0 and all din.ready=0.
- HOLD and LOCKED: sel = gidx; dout.valid = din[gidx].valid.
- All states:
  - din[sel].ready = dout.ready; all other din.ready = 0.
  - Handshake hs = dout.valid & dout.ready.
- IDLE transitions:
  - If dout.valid & ~dout.ready: HOLD, gidx<=pick. The dti rule forbids changing presented data before the handshake.
  - On hs with LOCK_EOT=1 and eot=0: LOCKED, gidx<=pick.
  - On any other hs: stay IDLE, ptr <= (pick+1) mod NUM.
- HOLD transitions:
  - On hs with LOCK_EOT=1 and eot=0: LOCKED.
  - On any other hs: IDLE, ptr <= (gidx+1) mod NUM.
  - No hs: stay in HOLD. A higher-priority requester raising valid must not steal the grant.
- LOCKED transitions:
  - On hs with eot=1: IDLE, ptr <= (gidx+1) mod NUM.
  - Otherwise stay LOCKED.
  - While LOCKED, din[gidx].valid low gives dout.valid=0, and the grant is kept.
- locked <= (next state == LOCKED), registered.
- Index wrap: NUM-1 + 1 -> 0. Requester NUM-1 being served is followed by a scan starting at 0.
- Reset mid-transaction (HOLD or LOCKED): next cycle is IDLE with ptr=0. The held beat is dropped and no ready is issued during the reset cycle.
- Fairness: with all requesters continuously valid and LOCK_EOT=0, the grant order is 0,1,...,NUM-1,0,... with one beat each.
- Non-power-of-2 NUM: sel never exceeds NUM-1.

Decomposition:
- Package decouple_arb_pkg:
  - typedef enum arb_state_t {IDLE, HOLD, LOCKED};
  - function rr_next(idx, num) for the wrap increment.
- One combinational sub-module rr_priority_pick:
  - Inputs: valid vector [NUM] and ptr.
  - Outputs: any_valid and pick index.
  - Implemented as a doubled-vector scan.

Test Plan:
- NUM=4, LOCK_EOT=0, all valid, dout.ready=1 -> sel sequence 0,1,2,3,0,1 on consecutive cycles; locked stays 0.
- NUM=4, only din[2] valid with data 0x1234, dout.ready=0 for 3 cycles, then din[0] becomes valid, then ready=1 -> dout.data={2,0x1234} stable throughout; the handshake goes to 2; the next grant is 0.
- LOCK_EOT=1, NUM=2:
  - Stimulus: din[1] sends 3 beats with eot on the 3rd, din[1].valid gaps 1 cycle mid-packet; din[0] is always valid.
  - Required: all 3 beats sel=1; dout.valid=0 during the gap; locked=1 from after beat 1 until after beat 3; then sel=0.
- NUM=3 wrap: ptr at 2 with din[2] and din[0] valid -> 2 served, then 0; sel never equals 3.
- rst asserted for 1 cycle while LOCKED on index 1 -> all din.ready=0 during reset; next cycle locked=0, state IDLE, and with all valid the first sel=0.
- No requester valid for 5 cycles -> dout.valid=0, all ready=0, ptr unchanged.
